// File: rtl/trap_controller_if.sv
// trap_controller_if: signal bundle between the core (master) and the
// machine-mode trap controller (slave).
//   Decoder side : Int, IntData, IntAck, TrapExit, CurrentPC
//   Interrupt    : ExtIrq
//   CSR unit     : MtvecWe, MtvecData, MieWe, MieData
//   Fetch        : PcSetEn, PcSetValue
//   CSR readback : Mepc, Mcause, Mtvec, Mie
interface trap_controller_if;
  logic        Int;
  logic [31:0] IntData;
  logic        IntAck;
  logic        TrapExit;
  logic        ExtIrq;
  logic [31:0] CurrentPC;
  logic        MtvecWe;
  logic [31:0] MtvecData;
  logic        MieWe;
  logic        MieData;
  logic        PcSetEn;
  logic [31:0] PcSetValue;
  logic [31:0] Mepc;
  logic [31:0] Mcause;
  logic [31:0] Mtvec;
  logic        Mie;

  modport master (
    output Int, IntData, TrapExit, ExtIrq, CurrentPC,
           MtvecWe, MtvecData, MieWe, MieData,
    input  IntAck, PcSetEn, PcSetValue, Mepc, Mcause, Mtvec, Mie
  );

  modport slave (
    input  Int, IntData, TrapExit, ExtIrq, CurrentPC,
           MtvecWe, MtvecData, MieWe, MieData,
    output IntAck, PcSetEn, PcSetValue, Mepc, Mcause, Mtvec, Mie
  );
endinterface

// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap responder for the RV32 core.
// Accepts decoder exceptions (Int/IntData, acknowledged by IntAck) and one
// level-sensitive external interrupt (ExtIrq, gated by Mie), saves
// Mepc/Mcause, redirects fetch to Mtvec, and on TrapExit (mret) redirects
// fetch back to Mepc. Owns mstatus.MIE (Mie) and MPIE.
// Ports:
//   Clk   - core clock, rising edge
//   Reset - synchronous, active-high
//   bus   - trap_controller_if.slave (decoder, CSR, fetch and readback signals)
// Parameters:
//   RESET_MTVEC - Mtvec after reset
//   EXT_CAUSE   - Mcause written for an external interrupt
// Build option:
//   TRAP_VECTORED_EN - Mtvec[1:0] writable; mode 01 vectors interrupts to
//                      base + 4*cause. Undefined: every trap goes to base.
module trap_controller #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter logic [31:0] EXT_CAUSE   = 32'h8000_000B
) (
  input logic            Clk,
  input logic            Reset,
  trap_controller_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ENTER   = 2'd1;
  localparam logic [1:0] HANDLER = 2'd2;
  localparam logic [1:0] EXIT    = 2'd3;

  logic [1:0]  state;
  logic        mpie;

  logic        canTake;
  logic        take;
  logic [31:0] takeCause;
  logic [31:0] baseTarget;
  logic [31:0] enterTarget;
  logic [31:0] mtvecNext;

  always_comb begin
    canTake    = (state == IDLE) || (state == HANDLER);
    take       = canTake && (bus.Int || (bus.ExtIrq && bus.Mie));
    takeCause  = bus.Int ? bus.IntData : EXT_CAUSE;
    // Target uses the current (pre-write) Mtvec so a same-cycle CSR write
    // does not affect the trap being taken.
    baseTarget  = {bus.Mtvec[31:2], 2'b00};
    enterTarget = baseTarget;
`ifdef TRAP_VECTORED_EN
    if ((bus.Mtvec[1:0] == 2'b01) && takeCause[31])
      enterTarget = baseTarget + {takeCause[29:0], 2'b00};
    mtvecNext = bus.MtvecData;
`else
    mtvecNext      = bus.MtvecData;
    mtvecNext[1:0] = 2'b00;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state          <= IDLE;
      mpie           <= 1'b0;
      bus.IntAck     <= 1'b0;
      bus.PcSetEn    <= 1'b0;
      bus.PcSetValue <= '0;
      bus.Mepc       <= '0;
      bus.Mcause     <= '0;
      bus.Mtvec      <= RESET_MTVEC;
      bus.Mie        <= 1'b0;
    end else begin
      bus.IntAck  <= 1'b0;
      bus.PcSetEn <= 1'b0;
      if (bus.MtvecWe) bus.Mtvec <= mtvecNext;
      // Software Mie write; overridden below by take/exit updates.
      if (bus.MieWe) bus.Mie <= bus.MieData;
      case (state)
        IDLE, HANDLER: begin
          if (take) begin
            state          <= ENTER;
            bus.Mepc       <= bus.CurrentPC;
            bus.Mcause     <= takeCause;
            mpie           <= bus.Mie;
            bus.Mie        <= 1'b0;
            bus.IntAck     <= bus.Int;
            bus.PcSetEn    <= 1'b1;
            bus.PcSetValue <= enterTarget;
          end else if (bus.TrapExit) begin
            state          <= EXIT;
            bus.Mie        <= mpie;
            mpie           <= 1'b1;
            bus.PcSetEn    <= 1'b1;
            bus.PcSetValue <= bus.Mepc;
          end
        end
        ENTER:   state <= HANDLER;
        EXIT:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Machine-mode trap responder for the RV32 core.
- Takes the decoder's exception request (Int/IntData), handshakes it with IntAck, and latches mepc/mcause.
- Redirects fetch to mtvec; on TrapExit (mret) redirects fetch back to mepc.
- Also arbitrates one level-sensitive external interrupt line and owns mstatus.MIE/MPIE.

Parameters:
- RESET_MTVEC, 32'h00000000, mtvec value after reset.
- EXT_CAUSE, 32'h8000000B, mcause written for an external interrupt (MSB=1, machine external).

Ports:
- Clk  in  1  core clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Int  in  1  exception request from decoder; held high until IntAck.
- IntData  in  32  exception cause code from decoder (e.g. 2, 3, 11).
- IntAck  out  1  one-cycle acknowledge of Int.
- TrapExit  in  1  mret decoded; single-cycle pulse.
- ExtIrq  in  1  level-sensitive external interrupt request.
- CurrentPC  in  32  PC of the instruction in decode; saved to mepc.
- MtvecWe  in  1  mtvec write strobe (CSR unit).
- MtvecData  in  32  mtvec write data.
- MieWe  in  1  mstatus.MIE write strobe.
- MieData  in  1  mstatus.MIE write data.
- PcSetEn  out  1  one-cycle fetch redirect strobe.
- PcSetValue  out  32  redirect target, valid when PcSetEn=1.
- Mepc  out  32  saved trap PC.
- Mcause  out  32  saved trap cause.
- Mtvec  out  32  trap vector register.
- Mie  out  1  global interrupt enable.

Behaviour:
- Reset: state=IDLE. IntAck=0, PcSetEn=0, PcSetValue=0, Mepc=0, Mcause=0, Mtvec=RESET_MTVEC, Mie=0, internal MPIE=0.
- States:
  - IDLE: not in a handler.
  - ENTER: one cycle.
  - HANDLER: in a handler.
  - EXIT: one cycle.
- Take condition, evaluated in IDLE and HANDLER:
  - Int=1 → take, cause = IntData.
  - Else if ExtIrq=1 and Mie=1 → take, cause = EXT_CAUSE.
  - Int has priority over ExtIrq when both are high in the same cycle.
- On take, at the edge: Mepc<=CurrentPC, Mcause<=cause, MPIE<=Mie, Mie<=0, state<=ENTER.
- ENTER, for exactly one cycle:
  - PcSetEn=1, PcSetValue={Mtvec[31:2],2'b00}.
  - IntAck=1 only if the take was from Int.
  - Next state = HANDLER.
  - Int and ExtIrq are ignored in this cycle.
- HANDLER:
  - Int=1 causes a nested take; Mepc/Mcause are overwritten and MPIE<=0 (Mie is already 0).
  - ExtIrq is masked unless software sets Mie via MieWe.
  - TrapExit=1 (and no take) → state<=EXIT, Mie<=MPIE, MPIE<=1.
  - Int and TrapExit in the same cycle: Int wins, TrapExit is dropped.
- EXIT, for one cycle: PcSetEn=1, PcSetValue=Mepc; next state = IDLE.
- TrapExit in IDLE is legal (mret outside a handler): same action as in HANDLER, goes to EXIT.
- Output timing:
  - IntAck, PcSetEn and PcSetValue are registered; latency from request sampled to redirect is 1 cycle.
  - PcSetValue holds its last value when PcSetEn=0.
- CSR writes:
  - MtvecWe writes Mtvec<=MtvecData, with bits [1:0] forced to 00 unless the optional feature is present.
  - A write in the same cycle as a take still updates Mtvec, but ENTER uses the pre-write value.
  - MieWe writes Mie, except on a take edge, where the take's Mie<=0 wins.
- Reset asserted in any state: all registers return to reset values on that edge; no PcSetEn pulse follows.
- Int still high after IntAck (decoder one cycle late to drop it): in HANDLER this is treated as a new exception. The decoder must clear Int in the IntAck cycle.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- Defined:
  - Mtvec[1:0] is writable.
  - If Mtvec[1:0]==01 and Mcause[31]==1, the ENTER target = {Mtvec[31:2],2'b00} + 4*Mcause[30:0] (32-bit wrap).
  - Exceptions always go to the base.
- Undefined: Mtvec[1:0] reads 00 and every trap targets the base.

Test Plan:
- Reset, then Mtvec write 0x100, CurrentPC=0x40, Int=1 with IntData=2 → next cycle IntAck=1, PcSetEn=1, PcSetValue=0x100; Mepc=0x40, Mcause=2, Mie=0.
- In HANDLER, pulse TrapExit → next cycle PcSetEn=1, PcSetValue=0x40, Mie restored to its pre-trap value, state IDLE.
- Mie=1, ExtIrq=1 and Int=1 (IntData=11) in the same cycle → Mcause=11, IntAck=1. Then mret with ExtIrq still high → after EXIT, take with Mcause=0x8000000B and no IntAck.
- Mie=0, ExtIrq=1 for 10 cycles → no PcSetEn. Then MieWe=1, MieData=1 → take on the following cycle.
- Int in HANDLER (IntData=3, CurrentPC=0x120) → Mepc=0x120, Mcause=3, PcSetValue=0x100. Int and TrapExit together → Int wins.
- With TRAP_VECTORED_EN: Mtvec=0x201, Mie=1, ExtIrq → PcSetValue=0x200+44=0x22C. Without the macro: PcSetValue=0x200. Separately, Reset asserted in ENTER → PcSetEn=0 on the next cycle.
